// File: rtl/sram_loader.sv
// Streams a block of words into consecutive SRAM addresses from 0, then holds
// the buffer valid for the datapath until the consumer releases it.
module sram_loader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] sram_waddr,
    output logic [DATA_WIDTH-1:0] sram_din,
    output logic                  sram_wen,
    output logic                  sram_chip_en,
    output logic                  buf_valid,
    output logic [ADDR_WIDTH:0]   buf_count,
    input  logic                  consume_done,
    output logic                  busy,
    output logic                  err_len
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_FULL  = 2'd3;

    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);

    logic [1:0]          state;
    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] target;
    logic                xfer;
    logic                final_xfer;
    logic                len_ok;

    // The pointer guard keeps a write at or beyond target impossible even if
    // the FSM were to linger in LOAD.
    assign in_ready   = (state == S_LOAD) && (wr_ptr < target);
    assign xfer       = in_valid && in_ready;
    assign final_xfer = in_last || (wr_ptr == target - ONE);
    assign len_ok     = (len != '0) && (len <= DEPTH_L);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            wr_ptr       <= '0;
            target       <= '0;
            buf_count    <= '0;
            sram_waddr   <= '0;
            sram_din     <= '0;
            sram_wen     <= 1'b0;
            sram_chip_en <= 1'b0;
            buf_valid    <= 1'b0;
            busy         <= 1'b0;
            err_len      <= 1'b0;
        end else begin
            // Write port: one-cycle latency from the accepting handshake.
            sram_wen     <= xfer;
            sram_chip_en <= xfer;
            if (xfer) begin
                sram_waddr <= wr_ptr[ADDR_WIDTH-1:0];
                sram_din   <= in_data;
                wr_ptr     <= wr_ptr + ONE;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            target  <= len;
                            wr_ptr  <= '0;
                            err_len <= 1'b0;
                            busy    <= 1'b1;
                            state   <= S_LOAD;
                        end else begin
                            err_len <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (xfer && final_xfer) begin
                        buf_count <= wr_ptr + ONE;
                        state     <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    buf_valid <= 1'b1;
                    state     <= S_FULL;
                end
                default: begin
                    if (consume_done) begin
                        buf_valid <= 1'b0;
                        buf_count <= '0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/sram_loader.md
Name: sram_loader

Overview:
- Write-side front end for the MAC datapath's SRAM.
- Accepts a stream of DATA_WIDTH words over a valid/ready handshake and writes them to consecutive SRAM addresses starting at 0.
- When the block is loaded, raises buf_valid to the datapath controller, which reads and accumulates the words.
- Holds the buffer until the consumer signals release, then rearms for the next block.

Parameters:
ADDR_WIDTH, 4, SRAM address width
DATA_WIDTH, 32, word width
DEPTH, 16, SRAM depth in words (<= 2^ADDR_WIDTH)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-low
start  in  1  one-cycle pulse; begins a load of len words
len  in  ADDR_WIDTH+1  requested word count, sampled on start
in_valid  in  1  producer has a word on in_data
in_data  in  DATA_WIDTH  input word
in_last  in  1  marks the final word (early termination), qualified by in_valid
in_ready  out  1  loader accepts a word this cycle
sram_waddr  out  ADDR_WIDTH  SRAM write address
sram_din  out  DATA_WIDTH  SRAM write data
sram_wen  out  1  SRAM write enable
sram_chip_en  out  1  SRAM chip enable; equals sram_wen
buf_valid  out  1  buffer loaded and stable
buf_count  out  ADDR_WIDTH+1  number of valid words in the buffer
consume_done  in  1  one-cycle pulse from consumer; releases the buffer
busy  out  1  high in LOAD, FLUSH and FULL
err_len  out  1  sticky; a start was given with an illegal len

Behaviour:
- All outputs are registered except in_ready, which is combinational from the state and counter.
- Reset (rst=0 at a clock edge), including mid-load: state IDLE; wr_ptr, target, buf_count, sram_waddr and sram_din = 0; sram_wen, sram_chip_en, buf_valid, busy and err_len = 0. SRAM contents are not cleared.
- Handshake: a transfer occurs in a cycle where in_valid && in_ready. in_data must be held stable while in_valid=1 and in_ready=0.
- State IDLE: in_ready=0.
  - start with 1 <= len <= DEPTH: target <= len, wr_ptr <= 0, state -> LOAD.
  - start with len==0 or len>DEPTH: err_len <= 1, stay in IDLE.
  - err_len clears only on the next legal start.
- State LOAD: in_ready=1.
  - Each transfer in cycle k: sram_wen/sram_chip_en=1, sram_waddr=wr_ptr, sram_din=in_data, all during cycle k+1 (one-cycle write latency). wr_ptr increments at the end of cycle k.
  - A transfer is final when in_last=1 or wr_ptr==target-1. On the final transfer, buf_count <= wr_ptr+1 and state -> FLUSH, so in_ready=0 in cycle k+1.
  - in_last on a word beyond target cannot occur; the block terminates at target regardless of in_last.
- State FLUSH (one cycle): the final SRAM write is issued; state -> FULL. buf_valid=1 from cycle k+2.
- State FULL: buf_valid=1, buf_count stable, in_ready=0.
  - consume_done -> buf_valid <= 0, buf_count <= 0, state -> IDLE.
  - New start may be accepted from the following cycle.
- start outside IDLE is ignored, with no err_len.
- consume_done outside FULL is ignored.
- sram_wen deasserts the cycle after each write unless another transfer occurred.
- No write is ever issued to an address >= target.
- busy=1 in LOAD, FLUSH and FULL.
- Simultaneous start and consume_done in FULL: consume_done acts; start is ignored.

Test Plan:
- Reset, then start len=4 and stream 0x11,0x22,0x33,0x44 with in_valid continuous -> sram_wen pulses 4 cycles at addr 0..3 with those data; buf_valid=1, buf_count=4 two cycles after the last handshake; consume_done -> buf_valid=0, busy=0.
- start len=16 with in_valid toggling 1/0 every cycle -> exactly 16 writes at addr 0..15; in_ready=0 from the cycle after the 16th transfer; buf_count=16.
- start len=8, in_last asserted with the 3rd word -> 3 writes (addr 0..2), buf_count=3, no write at addr 3.
- start with len=0 and then len=17 -> err_len=1, state stays IDLE, no sram_wen; then start len=2 -> err_len clears and a normal load follows.
- rst driven low after 2 of 5 words -> next edge: all outputs 0, in_ready=0, busy=0; a subsequent start len=1 loads correctly at addr 0.
- In FULL: start pulse ignored and buf_count held; consume_done in IDLE has no effect; start and consume_done together in FULL -> returns to IDLE, no new load.
